// File: rtl/branch_predict_unit.sv
// Branch predictor: 2-bit counter BHT plus direct-mapped BTB, with execute-stage resolution.
// Latency: prediction and resolution are combinational; table updates are visible the cycle after resolve.
// Backpressure: none; every valid lookup and resolve is accepted each cycle. Optional counters behind BPU_STATS_EN.
module branch_predict_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter int         BTB_ENTRIES = 16,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_jalr,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_taken,
  output logic [XLEN-1:0] ex_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int BHT_IW = $clog2(BHT_ENTRIES);
  localparam int BTB_IW = $clog2(BTB_ENTRIES);
  localparam int TAG_W  = XLEN - BTB_IW - 2;

  logic [1:0]             bht_ctr [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_vld;
  logic [BTB_ENTRIES-1:0] btb_jmp;
  logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_tgt [BTB_ENTRIES];

  logic [BHT_IW-1:0] if_bht_idx, ex_bht_idx;
  logic [BTB_IW-1:0] if_btb_idx, ex_btb_idx;
  logic [TAG_W-1:0]  if_tag, ex_tag;
  logic              if_hit;
  logic              br_cond;
  logic              is_br;
  logic [XLEN-1:0]   jalr_sum;
  logic [1:0]        ex_ctr;
  logic              ctr_upd;
  logic              btb_upd;

  assign if_bht_idx = if_pc[BHT_IW+1:2];
  assign if_btb_idx = if_pc[BTB_IW+1:2];
  assign if_tag     = if_pc[XLEN-1:BTB_IW+2];
  assign ex_bht_idx = ex_pc[BHT_IW+1:2];
  assign ex_btb_idx = ex_pc[BTB_IW+1:2];
  assign ex_tag     = ex_pc[XLEN-1:BTB_IW+2];
  assign ex_ctr     = bht_ctr[ex_bht_idx];

  // Fetch-side lookup from registered tables only (no bypass of same-cycle updates)
  always_comb begin
    if_hit      = btb_vld[if_btb_idx] & (btb_tag[if_btb_idx] == if_tag);
    pred_taken  = if_valid & if_hit & (btb_jmp[if_btb_idx] | bht_ctr[if_bht_idx][1]);
    pred_target = if_hit ? btb_tgt[if_btb_idx] : if_pc + XLEN'(4);
  end

  // Execute-side resolution; a jump flagged together with a branch is treated as a jump
  always_comb begin
    br_cond = 1'b0;
    case (ex_funct3)
      3'b000:  br_cond = (ex_rs1 == ex_rs2);
      3'b001:  br_cond = (ex_rs1 != ex_rs2);
      3'b100:  br_cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  br_cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  br_cond = (ex_rs1 <  ex_rs2);
      3'b111:  br_cond = (ex_rs1 >= ex_rs2);
      default: br_cond = 1'b0;
    endcase
    is_br       = ex_branch & ~ex_jump;
    jalr_sum    = ex_rs1 + ex_imm;
    ex_taken    = ex_valid & (ex_jump | (is_br & br_cond));
    ex_target   = (ex_jalr & ex_jump) ? {jalr_sum[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
    redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
    mispredict  = ex_valid & (ex_branch | ex_jump) &
                  ((ex_taken != ex_pred_taken) | (ex_taken & (ex_target != ex_pred_target)));
    ctr_upd     = ex_valid & is_br & (ex_funct3 != 3'b010) & (ex_funct3 != 3'b011);
    btb_upd     = ex_valid & (ex_branch | ex_jump) & ex_taken;
  end

  // Saturating counter training and BTB valid bits; reset may land at any time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_ctr[i] <= CTR_INIT;
      btb_vld <= '0;
    end else begin
      if (ctr_upd) begin
        if (ex_taken) begin
          if (ex_ctr != 2'b11) bht_ctr[ex_bht_idx] <= ex_ctr + 2'd1;
        end else begin
          if (ex_ctr != 2'b00) bht_ctr[ex_bht_idx] <= ex_ctr - 2'd1;
        end
      end
      if (btb_upd) btb_vld[ex_btb_idx] <= 1'b1;
    end
  end

  // BTB payload; guarded by the valid bit so it needs no reset
  always_ff @(posedge clk) begin
    if (btb_upd) begin
      btb_tag[ex_btb_idx] <= ex_tag;
      btb_tgt[ex_btb_idx] <= ex_target;
      btb_jmp[ex_btb_idx] <= ex_jump;
    end
  end

`ifdef BPU_STATS_EN
  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (ex_valid & (ex_branch | ex_jump)) stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit: directed scenarios plus randomized traffic.
// Expected values come from a table-level reference model keyed by PC arithmetic.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_branch_predict_unit;
  localparam int BHT = 64;
  localparam int BTB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
  logic [2:0]  ex_funct3;
  logic        ex_branch, ex_jump, ex_jalr;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BPU_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_predict_unit dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
    .ex_funct3(ex_funct3), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BPU_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: tables addressed by word address modulo table size
  int          m_ctr [BHT];
  bit          m_vld [BTB];
  logic [31:0] m_tag [BTB];
  logic [31:0] m_tgt [BTB];
  bit          m_jmp [BTB];
  logic [31:0] m_branches, m_mispred;

  bit          e_taken, e_mis, e_ptaken;
  logic [31:0] e_target, e_redir, e_ptgt;

  function automatic bit cond_true(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < BHT; i++) m_ctr[i] = 1;
    for (int i = 0; i < BTB; i++) m_vld[i] = 1'b0;
    m_branches = 0;
    m_mispred  = 0;
  endfunction

  function automatic void model_eval();
    int bi, ci;
    logic [31:0] sum;
    bit hit;
    e_taken  = ex_valid && (ex_jump || (ex_branch && cond_true(ex_funct3, ex_rs1, ex_rs2)));
    sum      = ex_rs1 + ex_imm;
    e_target = (ex_jalr && ex_jump) ? (sum & 32'hFFFF_FFFE) : ex_pc + ex_imm;
    e_mis    = ex_valid && (ex_branch || ex_jump) &&
               ((e_taken != ex_pred_taken) || (e_taken && e_target != ex_pred_target));
    e_redir  = e_taken ? e_target : ex_pc + 32'd4;
    bi       = int'((if_pc / 4) % BTB);
    ci       = int'((if_pc / 4) % BHT);
    hit      = m_vld[bi] && (m_tag[bi] == if_pc / (4 * BTB));
    e_ptaken = if_valid && hit && (m_jmp[bi] || m_ctr[ci] >= 2);
    e_ptgt   = hit ? m_tgt[bi] : if_pc + 32'd4;
  endfunction

  function automatic void model_commit();
    int bi, ci;
    model_eval();
    bi = int'((ex_pc / 4) % BTB);
    ci = int'((ex_pc / 4) % BHT);
    if (ex_valid && ex_branch && !ex_jump && ex_funct3 != 3'd2 && ex_funct3 != 3'd3)
      m_ctr[ci] = e_taken ? ((m_ctr[ci] < 3) ? m_ctr[ci] + 1 : 3) : ((m_ctr[ci] > 0) ? m_ctr[ci] - 1 : 0);
    if (ex_valid && (ex_branch || ex_jump) && e_taken) begin
      m_vld[bi] = 1'b1;
      m_tag[bi] = ex_pc / (4 * BTB);
      m_tgt[bi] = e_target;
      m_jmp[bi] = ex_jump;
    end
    if (ex_valid && (ex_branch || ex_jump)) m_branches = m_branches + 1;
    if (e_mis) m_mispred = m_mispred + 1;
  endfunction

  task automatic set_ex(input bit v, input bit br, input bit jmp, input bit jalr, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input bit ptk, input logic [31:0] ptgt);
    ex_valid = v; ex_branch = br; ex_jump = jmp; ex_jalr = jalr; ex_funct3 = f3;
    ex_pc = pc; ex_rs1 = a; ex_rs2 = b; ex_imm = imm;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] pc;
    if_valid = 1'b1; if_pc = 32'h100;
    set_ex(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h200, 32'd5, 32'd5, 32'h40, 1'b0, 32'h0);
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken got %b want 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target got %h want 00000104", pred_target); end
    n_cmp++; if (ex_taken !== 1'b0) begin n_fail++; $display("FAIL idle_ex_taken got %b want 0", ex_taken); end
    n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL idle_mispredict got %b want 0", mispredict); end
    for (int i = 0; i < 6; i++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      if_pc = pc;
      #1;
      n_cmp++; if (pred_taken !== 1'b0 || pred_target !== pc + 32'd4) begin
        n_fail++; $display("FAIL reset_lookup pc=%h got %b/%h want 0/%h", pc, pred_taken, pred_target, pc + 32'd4);
      end
    end
`ifdef BPU_STATS_EN
    n_cmp++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      n_fail++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
    end
`endif
    tick();
  endtask

  task automatic test_training();
    if_valid = 1'b1; if_pc = 32'h200;
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h200, 32'd5, 32'd5, 32'h40, 1'b0, 32'h204);
    #1;
    n_cmp++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL train_mispredict got %b want 1", mispredict); end
    n_cmp++; if (redirect_pc !== 32'h240) begin n_fail++; $display("FAIL train_redirect got %h want 00000240", redirect_pc); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL same_cycle_no_bypass got %b want 0", pred_taken); end
    tick();
    #1;
    n_cmp++; if (mispredict !== 1'b1 || ex_taken !== 1'b1) begin
      n_fail++; $display("FAIL train_second got mis=%b tk=%b want 1/1", mispredict, ex_taken);
    end
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h240) begin
      n_fail++; $display("FAIL trained_pred got %b/%h want 1/00000240", pred_taken, pred_target);
    end
    if_valid = 1'b0;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL if_invalid_pred got %b want 0", pred_taken); end
    tick();
  endtask

  task automatic test_saturation();
    if_valid = 1'b1; if_pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h200, 32'd5, 32'd5, 32'h40, 1'b1, 32'h240);
      #1;
      n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL sat_correct_%0d got %b want 0", i, mispredict); end
      tick();
    end
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h200, 32'd5, 32'd6, 32'h40, 1'b1, 32'h240);
    #1;
    n_cmp++; if (mispredict !== 1'b1 || redirect_pc !== 32'h204) begin
      n_fail++; $display("FAIL sat_not_taken got %b/%h want 1/00000204", mispredict, redirect_pc);
    end
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h240) begin
      n_fail++; $display("FAIL sat_after_decrement got %b/%h want 1/00000240", pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_jalr();
    if_valid = 1'b1; if_pc = 32'h304;
    set_ex(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h304, 32'h1003, 32'h0, 32'h4, 1'b1, 32'h1000);
    #1;
    n_cmp++; if (ex_target !== 32'h1006) begin n_fail++; $display("FAIL jalr_target got %h want 00001006", ex_target); end
    n_cmp++; if (mispredict !== 1'b1 || redirect_pc !== 32'h1006 || ex_taken !== 1'b1) begin
      n_fail++; $display("FAIL jalr_redirect got mis=%b rd=%h tk=%b want 1/00001006/1", mispredict, redirect_pc, ex_taken);
    end
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h1006) begin
      n_fail++; $display("FAIL jalr_btb got %b/%h want 1/00001006", pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_bltu_blt();
    if_valid = 1'b0; if_pc = 32'h0;
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 32'h400, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 32'h404);
    #1;
    n_cmp++; if (ex_taken !== 1'b0) begin n_fail++; $display("FAIL bltu_taken got %b want 0", ex_taken); end
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 32'h400, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 32'h404);
    #1;
    n_cmp++; if (ex_taken !== 1'b1 || ex_target !== 32'h420) begin
      n_fail++; $display("FAIL blt_taken got %b/%h want 1/00000420", ex_taken, ex_target);
    end
    tick();
  endtask

  task automatic test_alias();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    if_valid = 1'b1; if_pc = 32'h240;
    #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h244) begin
      n_fail++; $display("FAIL alias_240 got %b/%h want 0/00000244", pred_taken, pred_target);
    end
    if_pc = 32'h200;
    #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
      n_fail++; $display("FAIL alias_evicted_200 got %b/%h want 0/00000204", pred_taken, pred_target);
    end
    if_pc = 32'h400;
    #1;
    model_eval();
    n_cmp++; if (pred_taken !== e_ptaken || pred_target !== e_ptgt) begin
      n_fail++; $display("FAIL alias_owner_400 got %b/%h want %b/%h", pred_taken, pred_target, e_ptaken, e_ptgt);
    end
`ifdef BPU_STATS_EN
    n_cmp++; if (stat_branches !== m_branches || stat_mispredicts !== m_mispred) begin
      n_fail++; $display("FAIL stats_directed got %0d/%0d want %0d/%0d", stat_branches, stat_mispredicts, m_branches, m_mispred);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ops [4];
    logic [31:0] pc, imm;
    int kind;
    int bad;
    ops[0] = 32'd0; ops[1] = 32'd1; ops[2] = 32'd5; ops[3] = 32'hFFFF_FFFF;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      pc   = 32'h1000 + (32'($urandom_range(0, 3)) << 6) + (32'($urandom_range(0, 3)) << 2);
      imm  = 32'($urandom_range(0, 15)) * 32'd4 - 32'd32;
      kind = $urandom_range(0, 9);
      set_ex($urandom_range(0, 9) != 0, kind <= 6 || kind == 9, kind >= 7, kind == 8 || (kind == 9 && $urandom_range(0, 1) == 1),
             3'($urandom_range(0, 7)), pc, ops[$urandom_range(0, 3)], ops[$urandom_range(0, 3)], imm,
             1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? pc + imm : pc + 32'd4);
      if_valid = 1'($urandom_range(0, 3) != 0);
      if_pc    = 32'h1000 + (32'($urandom_range(0, 3)) << 6) + (32'($urandom_range(0, 3)) << 2);
      #1;
      model_eval();
      n_cmp++;
      if (pred_taken !== e_ptaken || pred_target !== e_ptgt || ex_taken !== e_taken ||
          ex_target !== e_target || mispredict !== e_mis || redirect_pc !== e_redir) begin
        n_fail++;
        if (bad < 8) $display("FAIL random_%0d pred=%b/%h ex=%b/%h mis=%b rd=%h want pred=%b/%h ex=%b/%h mis=%b rd=%h",
                              i, pred_taken, pred_target, ex_taken, ex_target, mispredict, redirect_pc,
                              e_ptaken, e_ptgt, e_taken, e_target, e_mis, e_redir);
        bad++;
      end
      tick();
    end
`ifdef BPU_STATS_EN
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (stat_branches !== m_branches || stat_mispredicts !== m_mispred) begin
      n_fail++; $display("FAIL stats_random got %0d/%0d want %0d/%0d", stat_branches, stat_mispredicts, m_branches, m_mispred);
    end
`endif
  endtask

  task automatic test_async_reset();
    if_valid = 1'b1; if_pc = 32'h304;
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h304, 32'h0, 32'h0, 32'h80, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL async_reset_immediate got %b want 0", pred_taken); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h308) begin
      n_fail++; $display("FAIL async_reset_304 got %b/%h want 0/00000308", pred_taken, pred_target);
    end
    if_pc = 32'h200;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL async_reset_200 got %b want 0", pred_taken); end
`ifdef BPU_STATS_EN
    n_cmp++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_stats got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
    end
`endif
    // One clean taken branch re-trains from CTR_INIT: 1 -> 2 means taken on the next lookup
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'h200, 32'd1, 32'd2, 32'h10, 1'b0, 32'h0);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h210) begin
      n_fail++; $display("FAIL retrain_after_reset got %b/%h want 1/00000210", pred_taken, pred_target);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if_valid = 1'b0; if_pc = 32'h0;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_training();
    test_saturation();
    test_jalr();
    test_bltu_blt();
    test_alias();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 64, meaning number of 2-bit counters (power of 2, ≥2).
REQ-003 SHALL have parameter BTB_ENTRIES, default 16, meaning number of direct-mapped target entries (power of 2, ≥2, ≤BHT_ENTRIES).
REQ-004 SHALL have parameter CTR_INIT, default 2'b01, meaning counter reset value (weakly not-taken).
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch lookup request.
- if_pc  in  XLEN  fetch PC.
- pred_taken  out  1  predicted taken.
- pred_target  out  XLEN  predicted target.
- ex_valid  in  1  execute-stage instruction valid.
- ex_pc, ex_rs1, ex_rs2, ex_imm  in  XLEN each  PC, operands, sign-extended immediate.
- ex_funct3  in  3  branch condition code.
- ex_branch, ex_jump, ex_jalr  in  1 each  conditional branch / JAL or JALR / JALR qualifier.
- ex_pred_taken, ex_pred_target  in  1/XLEN  prediction carried down the pipe.
- ex_taken  out  1  resolved direction.
- ex_target  out  XLEN  resolved target.
- mispredict  out  1  redirect required.
- redirect_pc  out  XLEN  correct next PC.

Function
REQ-006 SHALL index the BHT with if_pc/ex_pc[log2(BHT_ENTRIES)+1:2] and the BTB with [log2(BTB_ENTRIES)+1:2]; tag = remaining upper PC bits above the BTB index.
REQ-007 SHALL compute the prediction combinationally from registered state: pred_taken = if_valid & BTB hit & (entry.is_jump | counter[1]); pred_target = hit ? entry.target : if_pc+4; pred_taken=0 when if_valid=0.
REQ-008 SHALL resolve combinationally:
- Conditions: funct3 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
- 010/011: not taken.
- ex_jump forces taken.
REQ-009 SHALL compute ex_target = ex_jalr&ex_jump ? (ex_rs1+ex_imm) with bit0 cleared : ex_pc+ex_imm, modulo 2^XLEN.
REQ-010 SHALL assert mispredict = ex_valid & (ex_branch|ex_jump) & (ex_taken≠ex_pred_taken | (ex_taken & ex_target≠ex_pred_target)).
REQ-011 SHALL drive redirect_pc = ex_taken ? ex_target : ex_pc+4; mispredict=0 and ex_taken=0 when ex_valid=0.
REQ-012 SHALL, on the rising edge when ex_valid & ex_branch, saturate the indexed counter: +1 if taken (cap 3), −1 if not (floor 0); funct3 010/011 SHALL leave the counter unchanged.
REQ-013 SHALL, on the edge when ex_valid & (ex_branch|ex_jump) & ex_taken, write the BTB entry: valid=1, tag, target=ex_target, is_jump=ex_jump. Not-taken branches SHALL NOT modify the BTB.
REQ-014 SHALL give fetch lookups in the same cycle as an update to the same index the pre-update value; the new value is visible the next cycle (one-cycle update latency, no bypass).
REQ-015 SHALL ignore ex_branch and ex_jump both high; treat as a jump.

Reset
REQ-016 SHALL, while rst_n=0 (asynchronous, any time including mid-update), set all counters to CTR_INIT and all BTB valid bits to 0; targets/tags need not reset.
REQ-017 SHALL, after reset, give pred_taken=0 for every PC; combinational outputs follow inputs.

Configuration
REQ-018 SHALL, with BPU_STATS_EN defined, add outputs stat_branches and stat_mispredicts (32 bits each):
- reset to 0;
- stat_branches increments on each resolved ex_valid&(ex_branch|ex_jump);
- stat_mispredicts increments on each mispredict;
- both wrap 0xFFFFFFFF→0.
REQ-019 SHALL, without BPU_STATS_EN, omit both ports and counters entirely.

Verification
REQ-020 SHALL cover reset: after reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-021 SHALL cover counter training: BEQ at 0x200, rs1=rs2=5, imm=0x40, taken ×2 with ex_pred_taken=0:
- first resolve -> mispredict=1, redirect_pc=0x240;
- afterwards if_pc=0x200 -> pred_taken=1, pred_target=0x240.
REQ-022 SHALL cover saturation: four more taken then one not-taken at 0x200 -> counter 3→2, pred_taken still 1.
REQ-023 SHALL cover JALR: rs1=0x1003, imm=4, ex_pred_taken=1, ex_pred_target=0x1000 -> ex_target=0x1006, mispredict=1, redirect_pc=0x1006.
REQ-024 SHALL cover BLTU versus BLT: rs1=0xFFFFFFFF, rs2=1 -> BLTU ex_taken=0, BLT ex_taken=1.
REQ-025 SHALL cover aliasing and stats: a BTB tag mismatch at the same index -> pred_taken=0; with BPU_STATS_EN, counters match the resolved and mispredict totals.
